// File: rtl/column_input_conditioner.sv
// column_input_conditioner
// Turns four raw active-low column push buttons into a single, clean move
// strobe for the board FSM. Each button is synchronized and debounced. A
// small FSM then accepts exactly one column per press, rejects simultaneous
// presses, and ignores all input while the game is over.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous, active-low; clears all state
//   btn_n[3:0]   raw asynchronous buttons, active-low, bit n = column n
//   game_status  2'b00 = game in progress, anything else = game over / tie
//   enable       one-cycle move strobe, asserted while in_column is fresh
//   in_column    registered active-low one-hot column of the last accepted move
//   multi_press  sticky: a simultaneous multi-button press was rejected
module column_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16'd50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    input  logic [1:0] game_status,
    output logic       enable,
    output logic [3:0] in_column,
    output logic       multi_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCEPT  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       state_q, state_d;
    logic [3:0]       col_q, col_d;
    logic             multi_q, multi_d;
    logic             game_on;
    logic             released;

    // Debounce: the counter measures how long the synced bit has disagreed
    // with the debounced bit. Any agreement restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the flip point.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) db_d[i]  = sync2_q[i];
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign game_on  = (game_status == 2'b00);
    assign released = (db_q == 4'b1111);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        multi_d = multi_q;
        case (state_q)
            S_IDLE: begin
                if (!game_on) begin
                    state_d = S_LOCKED;
                end else if ($onehot(~db_q)) begin
                    // Column is captured on entry so it is valid alongside the strobe.
                    state_d = S_ACCEPT;
                    col_d   = db_q;
                    multi_d = 1'b0;
                end else if (!released) begin
                    state_d = S_WAIT;
                    multi_d = 1'b1;
                end
            end
            // Strobe is already committed; a game_status change here is seen next state.
            S_ACCEPT: state_d = S_WAIT;
            S_WAIT: begin
                if (released) state_d = game_on ? S_IDLE : S_LOCKED;
            end
            S_LOCKED: begin
                if (game_on && released) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            db_q    <= 4'b1111;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            state_q <= S_IDLE;
            col_q   <= 4'b1111;
            multi_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            col_q   <= col_d;
            multi_q <= multi_d;
        end
    end

    assign enable      = (state_q == S_ACCEPT);
    assign in_column   = col_q;
    assign multi_press = multi_q;

endmodule

// File: doc/column_input_conditioner.md
COLUMN_INPUT_CONDITIONER -- requirements
Module: column_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, consecutive stable cycles needed to accept a level change on any button.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of each debounce counter; DEBOUNCE_CYCLES SHALL be < 2^CNT_W.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 The block SHALL have port btn_n  input  4  raw asynchronous push buttons, active-low; bit0 = column 0 ... bit3 = column 3.
REQ-006 The block SHALL have port game_status  input  2  status from the board FSM; 2'b00 = game in progress, any other value = game over or tie.
REQ-007 The block SHALL have port enable  output  1  single-cycle move strobe to the board FSM.
REQ-008 The block SHALL have port in_column  output  4  active-low one-hot column code (4'b1110 = column 0 ... 4'b0111 = column 3), registered.
REQ-009 The block SHALL have port multi_press  output  1  sticky flag: a simultaneous multi-button press was rejected.

Function
REQ-010 Each btn_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each bit SHALL have its own debounce counter: counter clears when the synced bit equals the debounced bit; otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced bit takes the synced value and the counter clears.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced bit.
REQ-013 The FSM SHALL have states IDLE, ACCEPT, WAIT_RELEASE, LOCKED.
REQ-014 IDLE: if game_status != 2'b00, go LOCKED; else if the debounced vector has exactly one 0 bit, go ACCEPT; else if it has two or more 0 bits, set multi_press and go WAIT_RELEASE; else stay.
REQ-015 ACCEPT: in_column SHALL load the debounced vector and enable SHALL be 1 for exactly this one cycle; next state WAIT_RELEASE.
REQ-016 WAIT_RELEASE: stay until the debounced vector is 4'b1111, then go IDLE (or LOCKED if game_status != 2'b00); no enable in this state.
REQ-017 LOCKED: no enable; return to IDLE only when game_status == 2'b00 and the debounced vector is 4'b1111.
REQ-018 in_column SHALL hold its last accepted value between strobes and SHALL change only in ACCEPT.
REQ-019 Enable latency: a clean press held from clock edge k SHALL produce enable high at edge k+DEBOUNCE_CYCLES+3 (2 synchronizer, DEBOUNCE_CYCLES debounce, 1 FSM).
REQ-020 Held buttons SHALL NOT auto-repeat; one press = at most one enable.
REQ-021 Two buttons whose debounced falls land in different cycles SHALL yield one enable for the first; the second is ignored until full release.
REQ-022 multi_press SHALL clear only on reset or on the next ACCEPT.
REQ-023 game_status changing to non-zero while in ACCEPT SHALL NOT cancel the strobe already issued in that cycle.

Reset
REQ-024 On reset low: enable=0, in_column=4'b1111, multi_press=0, FSM=IDLE, synchronizer and debounced bits=1, counters=0.
REQ-025 Reset asserted mid-debounce or in WAIT_RELEASE SHALL discard the pending press; a button still held at reset release SHALL be accepted only after re-debounce (REQ-019 latency from release edge).

Verification (bench DEBOUNCE_CYCLES=4)
REQ-026 Press btn_n=4'b1101 clean, hold 20 cycles, release -> one enable pulse 7 cycles after press, in_column=4'b1101, held after release.
REQ-027 Bounce btn_n bit0 low/high every 2 cycles for 10 cycles then hold low -> exactly one enable, in_column=4'b1110, none during bounce.
REQ-028 btn_n=4'b0110 same cycle -> no enable, multi_press=1; release, then press 4'b0111 -> enable, in_column=4'b0111, multi_press=0.
REQ-029 game_status=2'b01, press 4'b1011 -> no enable; game_status=2'b00 with button still held -> no enable until release and new press.
REQ-030 Press 4'b1110, assert reset 3 cycles into debounce, deassert, keep holding -> no enable during reset, one enable 7 cycles after reset release, in_column=4'b1110.
REQ-031 Hold 4'b1011 for 100 cycles -> exactly one enable (no auto-repeat).
